// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_REGLENGTH = 3;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle of the serial adder; names carry the controller's point of view.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int REGLENGTH = DEFAULT_REGLENGTH
) ();

  logic                 start_i;
  logic                 abort_i;
  logic [REGLENGTH-1:0] a_i;
  logic [REGLENGTH-1:0] b_i;
  logic                 busy_o;
  logic                 done_o;
  logic [REGLENGTH:0]   result_o;

  modport master (
    output start_i, abort_i, a_i, b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, abort_i, a_i, b_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry, stepped once per enabled clock.
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_bit,
  input  logic b_bit,
  input  logic clr,
  input  logic en,
  output logic s_bit
);

  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = majority(a_bit, b_bit, carry_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign s_bit = a_bit ^ b_bit ^ carry_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: shifts operands LSB-first through one full-adder cell.
// reset is asynchronous and active-low.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int REGLENGTH = DEFAULT_REGLENGTH
) (
  input logic              clk,
  input logic              reset,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(REGLENGTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(REGLENGTH - 1);

  state_e               state_q, state_d;
  logic [REGLENGTH-1:0] aShift_q, aShift_d;
  logic [REGLENGTH-1:0] bShift_q, bShift_d;
  logic [CW-1:0]        count_q, count_d;
  logic [REGLENGTH:0]   result_q, result_d;

  logic cellClr;
  logic cellEn;
  logic sumBit;
  logic carryIn;
  logic carryOut;

  serial_fa_cell u_fa (
    .clk   (clk),
    .reset (reset),
    .a_bit (aShift_q[0]),
    .b_bit (bShift_q[0]),
    .clr   (cellClr),
    .en    (cellEn),
    .s_bit (sumBit)
  );

  // The cell exposes only its sum, so its carry is recovered as s ^ a ^ b.
  assign carryIn  = sumBit ^ aShift_q[0] ^ bShift_q[0];
  assign carryOut = majority(aShift_q[0], bShift_q[0], carryIn);

  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    count_d  = count_q;
    result_d = result_q;
    cellClr  = 1'b0;
    cellEn   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          aShift_d = bus.a_i;
          bShift_d = bus.b_i;
          count_d  = '0;
          result_d = '0;
          cellClr  = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // An abort leaves the partial result and the carry untouched.
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          cellEn            = 1'b1;
          result_d[count_q] = sumBit;
          aShift_d          = aShift_q >> 1;
          bShift_d          = bShift_q >> 1;
          if (count_q == LAST_BIT) begin
            result_d[REGLENGTH] = carryOut;
            count_d             = '0;
            state_d             = DONE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q == SHIFT);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule
